// File: rtl/cpu_clock_controller.sv
// ---------------------------------------------------------------------------
// cpu_clock_controller
// Run/halt/single-step controller for the RV32I core clock. It produces a
// one-cycle clock-enable pulse (cpu_clk_en) every div_active+1 clk_in cycles.
// The core runs on clk_in and is qualified by this enable.
//
// Optional build macro: CPU_CLK_CTRL_ENABLE_COUNT_EN
//   defined   -> enable_count counts issued enables (32-bit, wraps)
//   undefined -> enable_count is tied to zero
//
// Ports:
//   clk_in        board clock, the only clock
//   reset         asynchronous, active-high reset
//   run_req       pulse: enter RUN
//   halt_req      pulse: enter HALT (highest priority)
//   step_req      pulse: issue exactly one enable, then HALT
//   cfg_we        divisor write strobe
//   cfg_div       new divisor value
//   bp_hit        breakpoint match, honoured only while cpu_clk_en=1 in RUN
//   cpu_clk_en    registered enable pulse to the core
//   halted        registered; 1 when the controller is halted
//   step_done     registered pulse, the cycle after a step enable
//   div_active    divisor currently in use
//   enable_count  number of enables issued
// ---------------------------------------------------------------------------
module cpu_clock_controller #(
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned DEFAULT_DIV = 99
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 run_req,
    input  logic                 halt_req,
    input  logic                 step_req,
    input  logic                 cfg_we,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic                 bp_hit,
    output logic                 cpu_clk_en,
    output logic                 halted,
    output logic                 step_done,
    output logic [DIV_WIDTH-1:0] div_active,
    output logic [31:0]          enable_count
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [DIV_WIDTH-1:0] counter;
    logic [DIV_WIDTH-1:0] counter_next;
    logic [DIV_WIDTH-1:0] pending_div;
    logic [DIV_WIDTH-1:0] pending_div_next;
    logic                 pending_valid;
    logic                 pending_valid_next;
    logic [DIV_WIDTH-1:0] div_next;
    logic                 en_next;
    logic                 step_fire;
    logic                 step_fire_next;
    logic                 halted_next;
    logic                 tc;
    logic                 bp_stop;
    logic                 staged_valid;
    logic [DIV_WIDTH-1:0] staged_div;

    assign tc      = (counter == div_active);
    assign bp_stop = (state == ST_RUN) && cpu_clk_en && bp_hit;

    // A write arriving on the apply edge supersedes the older pending value.
    assign staged_valid = pending_valid || cfg_we;
    assign staged_div   = cfg_we ? cfg_div : pending_div;

    // State register
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state <= ST_HALT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; halt_req > step_req > run_req
    always_comb begin
        state_next = state;
        case (state)
            ST_HALT: begin
                if (halt_req) begin
                    state_next = ST_HALT;
                end else if (step_req) begin
                    state_next = ST_STEP;
                end else if (run_req) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_req || bp_stop) begin
                    state_next = ST_HALT;
                end
            end
            ST_STEP: begin
                if (halt_req || tc) begin
                    state_next = ST_HALT;
                end
            end
            default: state_next = ST_HALT;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        en_next            = 1'b0;
        step_fire_next     = 1'b0;
        counter_next       = '0;
        div_next           = div_active;
        pending_div_next   = pending_div;
        pending_valid_next = pending_valid;
        halted_next        = (state == ST_HALT);

        case (state)
            ST_RUN: begin
                if (!halt_req && !bp_stop && tc) begin
                    en_next = 1'b1;
                end
            end
            ST_STEP: begin
                if (!halt_req && tc) begin
                    en_next        = 1'b1;
                    step_fire_next = 1'b1;
                end
            end
            default: ;
        endcase

        if (state == ST_HALT) begin
            // Halted: writes take effect directly, nothing is ever staged
            if (cfg_we) begin
                div_next = cfg_div;
            end
            pending_valid_next = 1'b0;
        end else begin
            // Staged divisor lands with the next enable or on entering HALT
            if ((state_next == ST_HALT) || en_next) begin
                if (staged_valid) begin
                    div_next = staged_div;
                end
                pending_valid_next = 1'b0;
            end else if (cfg_we) begin
                pending_div_next   = cfg_div;
                pending_valid_next = 1'b1;
            end
            counter_next = ((state_next == ST_HALT) || en_next)
                         ? '0 : counter + DIV_WIDTH'(1);
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            counter       <= '0;
            div_active    <= DIV_WIDTH'(DEFAULT_DIV);
            pending_div   <= '0;
            pending_valid <= 1'b0;
            cpu_clk_en    <= 1'b0;
            step_fire     <= 1'b0;
            step_done     <= 1'b0;
            halted        <= 1'b1;
        end else begin
            counter       <= counter_next;
            div_active    <= div_next;
            pending_div   <= pending_div_next;
            pending_valid <= pending_valid_next;
            cpu_clk_en    <= en_next;
            step_fire     <= step_fire_next;
            step_done     <= step_fire;
            halted        <= halted_next;
        end
    end

`ifdef CPU_CLK_CTRL_ENABLE_COUNT_EN
    // Enable counter, cleared only by reset
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            enable_count <= 32'd0;
        end else if (en_next) begin
            enable_count <= enable_count + 32'd1;
        end
    end
`else
    assign enable_count = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_clock_controller.sv
// ---------------------------------------------------------------------------
// tb_cpu_clock_controller
// Directed scenarios plus randomized traffic for cpu_clock_controller,
// checked against a countdown-based reference model.
// ---------------------------------------------------------------------------
module tb_cpu_clock_controller;

    localparam int unsigned DW   = 16;
    localparam int unsigned DDIV = 99;

    localparam int M_HALT = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;

    logic          clk_in = 1'b0;
    logic          reset;
    logic          run_req;
    logic          halt_req;
    logic          step_req;
    logic          cfg_we;
    logic [DW-1:0] cfg_div;
    logic          bp_hit;
    logic          cpu_clk_en;
    logic          halted;
    logic          step_done;
    logic [DW-1:0] div_active;
    logic [31:0]   enable_count;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_mode;
    int          m_left;      // edges remaining before the enable edge
    int          m_div;
    int          m_pend;
    bit          m_pend_v;
    bit          m_en;
    bit          m_done;
    bit          m_sfire;
    bit          m_halted;
    int unsigned m_cnt;

    always #5 clk_in = ~clk_in;

    cpu_clock_controller #(
        .DIV_WIDTH   (DW),
        .DEFAULT_DIV (DDIV)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .run_req      (run_req),
        .halt_req     (halt_req),
        .step_req     (step_req),
        .cfg_we       (cfg_we),
        .cfg_div      (cfg_div),
        .bp_hit       (bp_hit),
        .cpu_clk_en   (cpu_clk_en),
        .halted       (halted),
        .step_done    (step_done),
        .div_active   (div_active),
        .enable_count (enable_count)
    );

    task automatic model_reset();
        m_mode   = M_HALT;
        m_left   = 0;
        m_div    = int'(DDIV);
        m_pend   = 0;
        m_pend_v = 1'b0;
        m_en     = 1'b0;
        m_done   = 1'b0;
        m_sfire  = 1'b0;
        m_halted = 1'b1;
        m_cnt    = 0;
    endtask

    // One clock edge of the reference model, using the inputs seen at the edge.
    task automatic model_edge();
        int nmode;
        bit fire;
        bit sfire;
        bit ev;
        int ep;
        if (reset) begin
            model_reset();
            return;
        end
        nmode = m_mode;
        fire  = 1'b0;
        sfire = 1'b0;
        ev    = m_pend_v || cfg_we;
        ep    = cfg_we ? int'(cfg_div) : m_pend;
        if (m_mode == M_HALT) begin
            if (!halt_req && step_req)     nmode = M_STEP;
            else if (!halt_req && run_req) nmode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (halt_req || (m_en && bp_hit)) nmode = M_HALT;
            else if (m_left == 0)              fire = 1'b1;
        end else begin
            if (halt_req) nmode = M_HALT;
            else if (m_left == 0) begin
                fire  = 1'b1;
                sfire = 1'b1;
                nmode = M_HALT;
            end
        end
        if (m_mode == M_HALT) begin
            if (cfg_we) m_div = int'(cfg_div);
            m_pend_v = 1'b0;
        end else if (nmode == M_HALT || fire) begin
            if (ev) m_div = ep;
            m_pend_v = 1'b0;
        end else if (cfg_we) begin
            m_pend   = int'(cfg_div);
            m_pend_v = 1'b1;
        end
        if (nmode == M_HALT)                  m_left = 0;
        else if (m_mode == M_HALT || fire)    m_left = m_div;
        else                                  m_left = m_left - 1;
        m_done   = m_sfire;
        m_sfire  = sfire;
        m_halted = (m_mode == M_HALT);
        m_en     = fire;
        m_cnt    = m_cnt + (fire ? 32'd1 : 32'd0);
        m_mode   = nmode;
    endtask

    function automatic logic [31:0] exp_count();
`ifdef CPU_CLK_CTRL_ENABLE_COUNT_EN
        return 32'(m_cnt);
`else
        return 32'd0;
`endif
    endfunction

    // Advance one clock; outputs are stable at the returned negedge.
    task automatic cyc();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        run_req  = 1'b0;
        halt_req = 1'b0;
        step_req = 1'b0;
        cfg_we   = 1'b0;
        bp_hit   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        cyc();
        cyc();
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL reset_halted got=%b want=1", halted); end
        total++; if (cpu_clk_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b want=0", cpu_clk_en); end
        total++; if (step_done !== 1'b0) begin bad++; $display("FAIL reset_step_done got=%b want=0", step_done); end
        total++; if (div_active !== DW'(DDIV)) begin bad++; $display("FAIL reset_div got=%0d want=%0d", div_active, DDIV); end
        total++; if (enable_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", enable_count); end
        reset = 1'b0;
        cyc();
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL reset_idle_halted got=%b want=1", halted); end
    endtask

    task automatic test_run_default();
        bit want;
        run_req = 1'b1;
        cyc();
        for (int i = 1; i <= 210; i++) begin
            cyc();
            want = (i == 100) || (i == 200);
            total++; if (cpu_clk_en !== want) begin bad++; $display("FAIL run_default_en i=%0d got=%b want=%b", i, cpu_clk_en, want); end
            total++; if (halted !== 1'b0) begin bad++; $display("FAIL run_default_halted i=%0d got=%b want=0", i, halted); end
        end
        total++; if (enable_count !== exp_count()) begin bad++; $display("FAIL run_default_count got=%0d want=%0d", enable_count, exp_count()); end
        halt_req = 1'b1;
        cyc();
        cyc();
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL run_default_stop got=%b want=1", halted); end
    endtask

    task automatic test_step();
        bit want_en;
        bit want_done;
        bit want_halt;
        cfg_we   = 1'b1;
        cfg_div  = DW'(3);
        step_req = 1'b1;
        cyc();
        total++; if (div_active !== DW'(3)) begin bad++; $display("FAIL step_div got=%0d want=3", div_active); end
        for (int i = 1; i <= 55; i++) begin
            cyc();
            want_en   = (i == 4);
            want_done = (i == 5);
            want_halt = !(i >= 1 && i <= 4);
            total++; if (cpu_clk_en !== want_en) begin bad++; $display("FAIL step_en i=%0d got=%b want=%b", i, cpu_clk_en, want_en); end
            total++; if (step_done !== want_done) begin bad++; $display("FAIL step_done i=%0d got=%b want=%b", i, step_done, want_done); end
            total++; if (halted !== want_halt) begin bad++; $display("FAIL step_halted i=%0d got=%b want=%b", i, halted, want_halt); end
        end
    endtask

    task automatic test_halt_at_tc();
        cfg_we  = 1'b1;
        cfg_div = DW'(4);
        cyc();
        run_req = 1'b1;
        cyc();
        for (int i = 1; i <= 4; i++) cyc();
        halt_req = 1'b1;
        cyc();
        total++; if (cpu_clk_en !== 1'b0) begin bad++; $display("FAIL halt_tc_en got=%b want=0", cpu_clk_en); end
        for (int i = 0; i < 20; i++) begin
            cyc();
            total++; if (cpu_clk_en !== 1'b0) begin bad++; $display("FAIL halt_tc_quiet i=%0d got=%b want=0", i, cpu_clk_en); end
        end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_tc_halted got=%b want=1", halted); end
        total++; if (div_active !== DW'(4)) begin bad++; $display("FAIL halt_tc_div got=%0d want=4", div_active); end
    endtask

    task automatic test_breakpoint();
        int seen;
        logic [31:0] want_cnt;
        reset = 1'b1;
        model_reset();
        cyc();
        reset   = 1'b0;
        cfg_we  = 1'b1;
        cfg_div = DW'(9);
        cyc();
        run_req = 1'b1;
        cyc();
        seen = 0;
        for (int i = 0; i < 200 && seen < 3; i++) begin
            cyc();
            if (cpu_clk_en) seen++;
        end
        total++; if (seen != 3) begin bad++; $display("FAIL bp_wait_enables got=%0d want=3", seen); end
        bp_hit = 1'b1;
        cyc();
        total++; if (cpu_clk_en !== 1'b0) begin bad++; $display("FAIL bp_en_after got=%b want=0", cpu_clk_en); end
        for (int i = 0; i < 30; i++) begin
            cyc();
            total++; if (cpu_clk_en !== 1'b0) begin bad++; $display("FAIL bp_quiet i=%0d got=%b want=0", i, cpu_clk_en); end
        end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL bp_halted got=%b want=1", halted); end
`ifdef CPU_CLK_CTRL_ENABLE_COUNT_EN
        want_cnt = 32'd3;
`else
        want_cnt = 32'd0;
`endif
        total++; if (enable_count !== want_cnt) begin bad++; $display("FAIL bp_count got=%0d want=%0d", enable_count, want_cnt); end
    endtask

    task automatic test_div_change();
        bit found;
        bit want;
        logic [DW-1:0] want_div;
        cfg_we  = 1'b1;
        cfg_div = DW'(9);
        cyc();
        run_req = 1'b1;
        cyc();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (cpu_clk_en) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL divchg_first got=0 want=1"); end
        for (int k = 1; k <= 20; k++) begin
            if (k == 5) begin
                cfg_we  = 1'b1;
                cfg_div = DW'(1);
            end
            cyc();
            want     = (k >= 10) && ((k - 10) % 2 == 0);
            want_div = (k >= 10) ? DW'(1) : DW'(9);
            total++; if (cpu_clk_en !== want) begin bad++; $display("FAIL divchg_en k=%0d got=%b want=%b", k, cpu_clk_en, want); end
            total++; if (div_active !== want_div) begin bad++; $display("FAIL divchg_div k=%0d got=%0d want=%0d", k, div_active, want_div); end
        end
    endtask

    task automatic test_all_reqs();
        for (int i = 0; i < 5; i++) cyc();
        halt_req = 1'b1;
        step_req = 1'b1;
        run_req  = 1'b1;
        cyc();
        for (int i = 0; i < 10; i++) begin
            total++; if (cpu_clk_en !== 1'b0) begin bad++; $display("FAIL allreq_en i=%0d got=%b want=0", i, cpu_clk_en); end
            cyc();
        end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL allreq_halted got=%b want=1", halted); end
    endtask

    task automatic test_reset_mid_step();
        cfg_we  = 1'b1;
        cfg_div = DW'(20);
        cyc();
        step_req = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) cyc();
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rststep_pre_halted got=%b want=0", halted); end
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL rststep_halted got=%b want=1", halted); end
        total++; if (cpu_clk_en !== 1'b0) begin bad++; $display("FAIL rststep_en got=%b want=0", cpu_clk_en); end
        total++; if (step_done !== 1'b0) begin bad++; $display("FAIL rststep_done got=%b want=0", step_done); end
        total++; if (div_active !== DW'(DDIV)) begin bad++; $display("FAIL rststep_div got=%0d want=%0d", div_active, DDIV); end
        total++; if (enable_count !== 32'd0) begin bad++; $display("FAIL rststep_count got=%0d want=0", enable_count); end
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            total++; if (cpu_clk_en !== 1'b0 || step_done !== 1'b0) begin bad++; $display("FAIL rststep_quiet i=%0d got=%b%b want=00", i, cpu_clk_en, step_done); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            run_req  = ($urandom_range(0, 15) == 0);
            halt_req = ($urandom_range(0, 39) == 0);
            step_req = ($urandom_range(0, 19) == 0);
            cfg_we   = ($urandom_range(0, 24) == 0);
            cfg_div  = DW'($urandom_range(0, 12));
            bp_hit   = ($urandom_range(0, 5) == 0);
            cyc();
            total++; if (cpu_clk_en !== m_en) begin bad++; $display("FAIL rand_en i=%0d got=%b want=%b", i, cpu_clk_en, m_en); end
            total++; if (halted !== m_halted) begin bad++; $display("FAIL rand_halted i=%0d got=%b want=%b", i, halted, m_halted); end
            total++; if (step_done !== m_done) begin bad++; $display("FAIL rand_step_done i=%0d got=%b want=%b", i, step_done, m_done); end
            total++; if (div_active !== DW'(m_div)) begin bad++; $display("FAIL rand_div i=%0d got=%0d want=%0d", i, div_active, m_div); end
            total++; if (enable_count !== exp_count()) begin bad++; $display("FAIL rand_count i=%0d got=%0d want=%0d", i, enable_count, exp_count()); end
            total++; if (cpu_clk_en && halted) begin bad++; $display("FAIL rand_en_while_halted i=%0d got=1 want=0", i); end
        end
    endtask

    initial begin
        reset    = 1'b1;
        run_req  = 1'b0;
        halt_req = 1'b0;
        step_req = 1'b0;
        cfg_we   = 1'b0;
        cfg_div  = '0;
        bp_hit   = 1'b0;
        test_reset();
        test_run_default();
        test_step();
        test_halt_at_tc();
        test_breakpoint();
        test_div_change();
        test_all_reqs();
        test_reset_mid_step();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_clock_controller.md
Name: cpu_clock_controller

Overview:
- Run/halt/single-step controller for the RV32I core's clock.
- Produces a one-cycle clock-enable pulse, cpu_clk_en, from the 100 MHz board clock. The enable rate is set by a divisor that can be reprogrammed at run time.
- Sits between the board clock/debug buttons and the core. The core is clocked by clk_in and qualified by cpu_clk_en, so no derived clock is needed.
- Supports free-run, halt, single-step and breakpoint halt.

Parameters:
- DIV_WIDTH, 16, width of the divisor register and the terminal counter.
- DEFAULT_DIV, 99, divisor loaded at reset. Enable period is DEFAULT_DIV+1 clk_in cycles, so 99 gives 1 MHz from 100 MHz.

Ports:
- clk_in  input  1  100 MHz board clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- run_req  input  1  one-cycle pulse: enter RUN.
- halt_req  input  1  one-cycle pulse: enter HALT.
- step_req  input  1  one-cycle pulse: issue exactly one enable, then HALT.
- cfg_we  input  1  divisor write strobe.
- cfg_div  input  DIV_WIDTH  new divisor value.
- bp_hit  input  1  breakpoint match from the core; sampled only while cpu_clk_en=1.
- cpu_clk_en  output  1  registered enable pulse to the core, one clk_in cycle wide.
- halted  output  1  registered; 1 when state is HALT.
- step_done  output  1  one-cycle pulse, registered, the cycle after a STEP enable.
- div_active  output  DIV_WIDTH  divisor currently in use.
- enable_count  output  32  number of enables issued (see Optional Feature).

Behaviour:
- Reset (async, active-high) forces:
  - state=HALT, counter=0, div_active=DEFAULT_DIV, pending_valid=0.
  - cpu_clk_en=0, step_done=0, halted=1, enable_count=0.
- States: HALT, RUN, STEP.
- Counter behaviour:
  - Held at 0 in HALT.
  - In RUN/STEP it increments by 1 per clk_in.
  - At counter==div_active the next edge sets counter<=0 and cpu_clk_en<=1 for exactly one cycle.
  - Enable period is div_active+1 cycles. The first enable after leaving HALT comes div_active+1 cycles after the transition edge.
- div_active=0 gives cpu_clk_en high every cycle in RUN. Counter arithmetic is unsigned DIV_WIDTH; there is no wrap past div_active.
- Transitions, with priority halt_req > step_req > run_req on simultaneous pulses:
  - HALT + step_req -> STEP.
  - HALT + run_req -> RUN.
  - RUN + halt_req -> HALT. Counter clears and no enable is issued on that edge, even at terminal count.
  - RUN + step_req or run_req: ignored.
  - STEP at terminal count -> HALT on the same edge that raises cpu_clk_en; step_done=1 the following cycle.
  - STEP + halt_req -> HALT with no enable and no step_done.
  - STEP + run_req: ignored.
- Breakpoint:
  - bp_hit=1 while cpu_clk_en=1 in RUN -> HALT on the next edge.
  - The counter clears, and no further enable is issued. The enable that caused the hit counts as issued.
- Divisor writes:
  - In HALT: cfg_we loads div_active directly on the next edge.
  - In RUN/STEP: the value is staged in a pending register. div_active updates on the terminal-count edge, i.e. with the next enable.
  - A later write before apply overwrites the pending value.
  - On entering HALT, any pending value is applied immediately.
- halted tracks state with one-cycle register latency; cpu_clk_en is never 1 while halted=1.
- Reset mid-operation aborts any step; no step_done is generated.

Optional Feature:
- Macro CPU_CLK_CTRL_ENABLE_COUNT_EN.
- Defined:
  - enable_count is a 32-bit register that increments on every edge where cpu_clk_en<=1.
  - Wraps 0xFFFFFFFF->0.
  - Cleared only by reset.
- Undefined: enable_count is tied to 32'd0 and the counter logic is absent.

Test Plan:
- Reset release, DEFAULT_DIV=99, run_req pulse -> first cpu_clk_en exactly 100 cycles after the RUN edge. Subsequent enables every 100 cycles, each 1 cycle wide; halted=0.
- HALT, cfg_we with cfg_div=3, step_req -> one cpu_clk_en 4 cycles later, step_done 1 cycle after that, halted=1. No further enables over 50 cycles.
- RUN with div=4, halt_req asserted in the same cycle counter==4 -> no enable on that edge, halted=1, counter=0.
- RUN with div=9, bp_hit=1 coincident with the 3rd enable -> HALT next cycle; enable_count=3 with the macro defined, 0 without.
- RUN with div=9, cfg_we with cfg_div=1 mid-period -> current period stays 10 cycles, then the period is 2. div_active changes on the enable edge.
- halt_req, step_req and run_req pulsed together in RUN -> HALT. Async reset asserted mid-STEP -> no enable, no step_done, all outputs return to reset values immediately.
